hazard_ctrl: RTL

Hazard resolution unit for the five-stage MIPS pipeline; it consumes the per-instruction Tuse/Tnew and register-address information produced by the decode-stage control unit. It tracks the destination register and remaining Tnew of every instruction in E, M and W in its own shadow pipeline. Each cycle it produces the stall request and the forwarding-mux selects for the D, E and M stages.

---
 rtl/hazard_ctrl.sv | 88 ++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard resolution unit for the five-stage MIPS pipeline.
// Ports:
//   clk, rst_n                    pipeline clock (rising edge), asynchronous active-low reset
//   D_rs, D_rt, D_A3              register addresses of the instruction in D
//   D_Tuse_rs, D_Tuse_rt          cycles until the operand is needed; 3 = not read
//   D_RegWrite, D_Tnew            write enable and Tnew of the instruction in D
//   stall                         freeze PC and F/D, load a bubble into D/E
//   fwd_D_rs, fwd_D_rt            D operand select: 0 = RF, 1 = W, 2 = M, 3 = E
//   fwd_E_rs, fwd_E_rt            E operand select: 0 = pipe reg, 1 = W, 2 = M
//   fwd_M_rt                      M store-data select: 0 = pipe reg, 1 = W
//   stall_cnt                     stall cycle counter, built only with HAZARD_PERF_CNT_EN
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_Tuse_rs,
  input  logic [1:0]  D_Tuse_rt,
  input  logic [4:0]  D_A3,
  input  logic        D_RegWrite,
  input  logic [1:0]  D_Tnew,
  output logic        stall,
  output logic [1:0]  fwd_D_rs,
  output logic [1:0]  fwd_D_rt,
  output logic [1:0]  fwd_E_rs,
  output logic [1:0]  fwd_E_rt,
  output logic        fwd_M_rt,
  output logic [31:0] stall_cnt
);
  logic [4:0] e_a3, e_rs, e_rt, m_a3, m_rt, w_a3;
  logic [1:0] e_tnew, m_tnew;
  logic       stall_rs, stall_rt;
  function automatic logic [1:0] satdec(input logic [1:0] x);
    return (x == 2'd0) ? 2'd0 : x - 2'd1;
  endfunction
  // The youngest stage whose A3 matches decides; if it is still computing it returns 0
  // and hides older stages, leaving the stall logic to cover the gap.
  function automatic logic [1:0] fwd_sel(input logic [4:0] r, input logic [4:0] ea3,
                                         input logic [1:0] etn, input logic [4:0] ma3,
                                         input logic [1:0] mtn, input logic [4:0] wa3);
    return (r == 5'd0) ? 2'd0 :
           (ea3 == r) ? ((etn == 2'd0) ? 2'd3 : 2'd0) :
           (ma3 == r) ? ((mtn == 2'd0) ? 2'd2 : 2'd0) :
           (wa3 == r) ? 2'd1 : 2'd0;
  endfunction
  assign stall_rs = (D_Tuse_rs != 2'd3) && (D_rs != 5'd0) &&
                    ((e_a3 == D_rs && e_tnew > D_Tuse_rs) || (m_a3 == D_rs && m_tnew > D_Tuse_rs));
  assign stall_rt = (D_Tuse_rt != 2'd3) && (D_rt != 5'd0) &&
                    ((e_a3 == D_rt && e_tnew > D_Tuse_rt) || (m_a3 == D_rt && m_tnew > D_Tuse_rt));
  assign stall    = stall_rs | stall_rt;
  assign fwd_D_rs = fwd_sel(D_rs, e_a3, e_tnew, m_a3, m_tnew, w_a3);
  assign fwd_D_rt = fwd_sel(D_rt, e_a3, e_tnew, m_a3, m_tnew, w_a3);
  // A zero E address never matches a non-zero register, so E is simply excluded here.
  assign fwd_E_rs = fwd_sel(e_rs, 5'd0, 2'd0, m_a3, m_tnew, w_a3);
  assign fwd_E_rt = fwd_sel(e_rt, 5'd0, 2'd0, m_a3, m_tnew, w_a3);
  assign fwd_M_rt = (m_rt != 5'd0) && (w_a3 == m_rt);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_a3   <= 5'd0;
      e_tnew <= 2'd0;
      e_rs   <= 5'd0;
      e_rt   <= 5'd0;
      m_a3   <= 5'd0;
      m_tnew <= 2'd0;
      m_rt   <= 5'd0;
      w_a3   <= 5'd0;
    end else begin
      e_a3   <= (stall || !D_RegWrite) ? 5'd0 : D_A3;
      e_tnew <= stall ? 2'd0 : satdec(D_Tnew);
      e_rs   <= stall ? 5'd0 : D_rs;
      e_rt   <= stall ? 5'd0 : D_rt;
      m_a3   <= e_a3;
      m_tnew <= satdec(e_tnew);
      m_rt   <= e_rt;
      w_a3   <= m_a3;
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= 32'd0;
    else if (stall && cnt != 32'hFFFF_FFFF) cnt <= cnt + 32'd1;
  end
  assign stall_cnt = cnt;
`else
  assign stall_cnt = 32'h0;
`endif
endmodule
